inst_decode: RTL
================

INST_DECODE -- requirements
Module: inst_decode

Interface
REQ-001 Parameter NREG, default 32, number of architectural registers; index width is clog2(NREG).
REQ-002 Parameter XLEN, default 32, register and datapath width in bits.
REQ-003 clk  input  1  single system clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-low.
REQ-005 inst  input  32  current instruction word from the fetch stage.
REQ-006 reg_write  input  1  write-back enable for this cycle.
REQ-007 wb_data  input  XLEN  write-back data.
REQ-008 rs1_data  output  XLEN  register-file read, port 1, index inst[19:15].
REQ-009 rs2_data  output  XLEN  register-file read, port 2, index inst[24:20].
REQ-010 imm32  output  32  sign-extended immediate, byte-offset form, ready for direct PC addition.

Function
REQ-011 Register file SHALL hold NREG x XLEN entries; write index = inst[11:7].
REQ-012 Write SHALL occur on rising clk when rst high, reg_write=1 and rd != 0; any other case leaves the array unchanged.
REQ-013 Register 0 SHALL read 0 at all times; writes to it are discarded.
REQ-014 Reads SHALL be combinational from inst; zero-cycle latency; written value visible on reads from the next cycle.
REQ-015 Immediate selection by opcode inst[6:0]: I-type (0000011, 0010011, 1100111) = sext(inst[31:20]).
REQ-016 S-type (0100011) = sext({inst[31:25], inst[11:7]}).
REQ-017 B-type (1100011) = sext({inst[31], inst[7], inst[30:25], inst[11:8], 1'b0}).
REQ-018 U-type (0110111, 0010111) = {inst[31:12], 12'b0}.
REQ-019 J-type (1101111) = sext({inst[31], inst[19:12], inst[20], inst[30:21], 1'b0}).
REQ-020 Any other opcode SHALL yield imm32 = 0.
REQ-021 Simultaneous write and read of the same nonzero index SHALL return the old value, unless REQ-027 applies.
REQ-022 Unknown/X inst SHALL NOT corrupt stored registers when reg_write=0.

Reset
REQ-023 rst low SHALL clear all registers to 0 immediately, independent of clk.
REQ-024 Reset asserted mid-write SHALL win; the targeted register reads 0 afterwards.
REQ-025 During reset rs1_data/rs2_data SHALL read 0; imm32 stays a pure function of inst.
REQ-026 Release of rst SHALL take effect at the first rising clk edge after deassertion; no write occurs on a cycle where rst is low.

Configuration
REQ-027 Macro WB_BYPASS_EN defined: a read whose index equals a concurrently written nonzero rd with reg_write=1 SHALL return wb_data in the same cycle.
REQ-028 Macro WB_BYPASS_EN undefined: no bypass mux; behaviour per REQ-021.

Structure
REQ-029 Shared package SHALL hold opcode constants (OP_LOAD, OP_IMM, OP_JALR, OP_STORE, OP_BRANCH, OP_LUI, OP_AUIPC, OP_JAL) and an imm-format enum (I, S, B, U, J, NONE).
REQ-030 Sub-module regfile SHALL contain the array, reset, write and read/bypass logic; immediate generation SHALL stay in the top level.

Verification
REQ-031 Reset: drive rst=0 mid-cycle, then read x1..x31 -> all 0 without waiting for a clk edge.
REQ-032 Write/read: inst=0x00500093 (addi x1,x0,5) with reg_write=1, wb_data=5; next cycle inst reading rs1=x1 -> rs1_data=5, and imm32 was 5.
REQ-033 x0 write: rd=0, reg_write=1, wb_data=0xDEADBEEF -> rs1_data for x0 stays 0.
REQ-034 Immediates: inst=0xFE000EE3 (beq, offset -4) -> imm32=0xFFFFFFFC; inst=0x123452B7 (lui) -> 0x12345000; inst=0xFFDFF06F (jal -4) -> 0xFFFFFFFC.
REQ-035 Same-cycle hazard: write x5=0x55 while reading x5 (old 0x11) -> 0x55 with WB_BYPASS_EN, 0x11 without.
REQ-036 Reset during write: rst falls in the same cycle as a write to x3 -> x3 reads 0 after reset release.

Source files
------------

// File: rtl/inst_decode_pkg.sv
// -----------------------------------------------------------------------------
// inst_decode_pkg
// Shared definitions for the decode stage: base-ISA opcode constants, the
// immediate-format enum and the opcode -> format classifier.
// -----------------------------------------------------------------------------
package inst_decode_pkg;

   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_IMM    = 7'b0010011;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;
   localparam logic [6:0] OP_JAL    = 7'b1101111;

   typedef enum logic [2:0] {
      IMM_I,
      IMM_S,
      IMM_B,
      IMM_U,
      IMM_J,
      IMM_NONE
   } imm_fmt_e;

   // Map an opcode to the layout of its immediate field.
   function automatic imm_fmt_e imm_fmt(input logic [6:0] opcode);
      case (opcode)
         OP_LOAD, OP_IMM, OP_JALR: return IMM_I;
         OP_STORE:                 return IMM_S;
         OP_BRANCH:                return IMM_B;
         OP_LUI, OP_AUIPC:         return IMM_U;
         OP_JAL:                   return IMM_J;
         default:                  return IMM_NONE;
      endcase
   endfunction

endpackage

// File: rtl/inst_decode_regfile.sv
// -----------------------------------------------------------------------------
// inst_decode_regfile
// NREG x XLEN architectural register file: two combinational read ports, one
// write port, register 0 hard-wired to zero, asynchronous active-low clear.
// Build option: define WB_BYPASS_EN to forward same-cycle write-back data to
// a read port whose index matches the write index; without it a concurrent
// read returns the value stored before the write.
//
// Ports
//   clk       system clock, writes on rising edge
//   rst       asynchronous active-low reset, clears every register
//   reg_write write enable
//   rd        write index
//   wb_data   write data
//   rs1, rs2  read indices
//   rs1_data, rs2_data  read data (zero while rst is low)
// -----------------------------------------------------------------------------
module inst_decode_regfile #(
   parameter int NREG = 32,
   parameter int XLEN = 32,
   parameter int AW   = $clog2(NREG)
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            reg_write,
   input  logic [AW-1:0]   rd,
   input  logic [XLEN-1:0] wb_data,
   input  logic [AW-1:0]   rs1,
   input  logic [AW-1:0]   rs2,
   output logic [XLEN-1:0] rs1_data,
   output logic [XLEN-1:0] rs2_data
);

   // Widened register count so an index can be range-checked when NREG is
   // not a power of two.
   localparam logic [AW:0] NREG_W = (AW+1)'(NREG);

   logic [XLEN-1:0] regs [NREG];
   logic            wr_en;

   assign wr_en = reg_write && (rd != '0) && ({1'b0, rd} < NREG_W);

   // NOTE: the array is cleared by the asynchronous reset because the
   // architecture requires every register to read zero right after reset;
   // this costs a reset net per flop, so it is not a pattern for plain RAMs.
   // Non-blocking assignments keep the write ordered after all same-edge reads.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < NREG; i++) regs[i] <= '0;
      end else if (wr_en) begin
         regs[rd] <= wb_data;
      end
   end

   // Stored value at idx; index 0 and out-of-range indices read as zero.
   function automatic logic [XLEN-1:0] stored(input logic [AW-1:0] idx);
      if (idx == '0 || ({1'b0, idx} >= NREG_W)) return '0;
      return regs[idx];
   endfunction

   always_comb begin
      rs1_data = '0;
      rs2_data = '0;
      if (rst) begin
         rs1_data = stored(rs1);
         rs2_data = stored(rs2);
`ifdef WB_BYPASS_EN
         // Forward the in-flight write; wr_en already excludes rd == 0.
         if (wr_en && rd == rs1) rs1_data = wb_data;
         if (wr_en && rd == rs2) rs2_data = wb_data;
`endif
      end
   end

endmodule

// File: rtl/inst_decode.sv
// -----------------------------------------------------------------------------
// inst_decode
// Decode stage: register-file reads addressed by the current instruction and
// the sign-extended, byte-offset immediate for that instruction.
// Build option: WB_BYPASS_EN (see inst_decode_regfile) enables write-back
// forwarding into the read ports.
//
// Ports
//   clk        system clock
//   rst        asynchronous active-low reset
//   inst       instruction word from fetch
//   reg_write  write-back enable (rd = inst[11:7])
//   wb_data    write-back data
//   rs1_data   register read, index inst[19:15]
//   rs2_data   register read, index inst[24:20]
//   imm32      decoded immediate, ready to add to the PC
// -----------------------------------------------------------------------------
module inst_decode
   import inst_decode_pkg::*;
#(
   parameter int NREG = 32,
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [31:0]     inst,
   input  logic            reg_write,
   input  logic [XLEN-1:0] wb_data,
   output logic [XLEN-1:0] rs1_data,
   output logic [XLEN-1:0] rs2_data,
   output logic [31:0]     imm32
);

   localparam int AW = $clog2(NREG);

   inst_decode_regfile #(
      .NREG (NREG),
      .XLEN (XLEN),
      .AW   (AW)
   ) u_regfile (
      .clk       (clk),
      .rst       (rst),
      .reg_write (reg_write),
      .rd        (inst[7 +: AW]),
      .wb_data   (wb_data),
      .rs1       (inst[15 +: AW]),
      .rs2       (inst[20 +: AW]),
      .rs1_data  (rs1_data),
      .rs2_data  (rs2_data)
   );

   // Immediate generation is purely combinational on inst, so it keeps
   // decoding normally while the register file is held in reset.
   // NOTE: imm32 is given a default before the case so that every path
   // assigns it and no latch is inferred.
   always_comb begin
      imm32 = '0;
      case (imm_fmt(inst[6:0]))
         IMM_I: imm32 = {{20{inst[31]}}, inst[31:20]};
         IMM_S: imm32 = {{20{inst[31]}}, inst[31:25], inst[11:7]};
         IMM_B: imm32 = {{19{inst[31]}}, inst[31], inst[7], inst[30:25],
                         inst[11:8], 1'b0};
         IMM_U: imm32 = {inst[31:12], 12'b0};
         IMM_J: imm32 = {{11{inst[31]}}, inst[31], inst[19:12], inst[20],
                         inst[30:21], 1'b0};
         default: imm32 = '0;
      endcase
   end

endmodule
